fifo_demux_rx: RTL

Packet-aware receive demultiplexer: reads bytes from one upstream FIFO, decodes a header word carrying a channel-select field and a payload-length code, and routes the header plus its payload words into one of NCH per-channel output FIFOs. It sits between the link receive FIFO and the protocol clients and generalises two-way routing to NCH channels. It stalls only on the addressed channel and discards packets addressed to non-existent channels, counting the drops.

---
 rtl/fifo_demux_rx.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/fifo_demux_rx.sv
// Packet-aware receive demux: pulls words from one upstream FIFO and routes each
// header plus its payload into one of NCH FWFT channel FIFOs, dropping bad channels.
module fifo_demux_rx #(
  parameter int unsigned NCH      = 4,
  parameter int unsigned DWIDTH   = 8,
  parameter int unsigned AWIDTH   = 3,
  parameter int unsigned SELSHIFT = 6,
  parameter int unsigned SELWIDTH = 2,
  parameter int unsigned CNTSHIFT = 3,
  parameter int unsigned CNTWIDTH = 3
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  output logic                  fifo_rden,
  input  logic                  fifo_rdempty,
  input  logic [DWIDTH-1:0]     fifo_rddata,
  input  logic [NCH-1:0]        ch_rden,
  output logic [NCH-1:0]        ch_rdempty,
  output logic [NCH*DWIDTH-1:0] ch_rddata,
  input  logic                  drop_clr,
  output logic [15:0]           drop_count,
  output logic                  busy
);

  localparam int unsigned DEPTH  = 1 << AWIDTH;
  localparam int unsigned LWIDTH = AWIDTH + 1;
  localparam int unsigned RWIDTH = (1 << CNTWIDTH) - 1;

  typedef enum logic [1:0] {S_HDR, S_PAYLOAD, S_DROP} state_t;

  state_t               state_q, state_d;
  logic [RWIDTH-1:0]    rem_q, rem_d;
  logic [SELWIDTH-1:0]  target_q, target_d;
  logic                 busy_q;
  logic [15:0]          drop_count_q;

  logic [DWIDTH-1:0]    skid0_q, skid1_q;
  logic [1:0]           skid_cnt_q;
  logic                 pend_q;
  logic                 en_q;
  logic [2:0]           occ_c;

  logic                 dispatch_c;
  logic                 wr_en_c;
  logic [SELWIDTH-1:0]  wr_sel_c;
  logic                 drop_inc_c;
  logic                 hdr_full_c;
  logic                 tgt_full_c;
  logic [NCH-1:0]       ch_full_c;

  logic [SELWIDTH-1:0]  hdr_chan_c;
  logic [CNTWIDTH-1:0]  hdr_code_c;
  logic [RWIDTH-1:0]    hdr_len_c;
  logic                 hdr_bad_c;
  logic                 head_valid_c;

  // Upstream pop: keep skid occupancy plus in-flight read below two entries
  assign occ_c     = 3'(skid_cnt_q) + 3'(pend_q) - 3'(dispatch_c);
  assign fifo_rden = en_q && !fifo_rdempty && (occ_c < 3'd2);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      en_q       <= 1'b0;
      pend_q     <= 1'b0;
      skid_cnt_q <= 2'd0;
      skid0_q    <= '0;
      skid1_q    <= '0;
    end else begin
      en_q       <= 1'b1;
      pend_q     <= fifo_rden;
      skid_cnt_q <= 2'(occ_c);
      if (dispatch_c) skid0_q <= skid1_q;
      // Arriving word lands behind whatever survives this cycle's dispatch
      if (pend_q) begin
        if ((skid_cnt_q - 2'(dispatch_c)) == 2'd0) skid0_q <= fifo_rddata;
        else                                       skid1_q <= fifo_rddata;
      end
    end
  end

  assign head_valid_c = (skid_cnt_q != 2'd0);
  assign hdr_chan_c   = skid0_q[SELSHIFT +: SELWIDTH];
  assign hdr_code_c   = skid0_q[CNTSHIFT +: CNTWIDTH];
  assign hdr_len_c    = (hdr_code_c == '0) ? '0
                                           : (RWIDTH'(1) << (hdr_code_c - CNTWIDTH'(1)));
  assign hdr_bad_c    = (32'(hdr_chan_c) >= NCH);

  always_comb begin
    hdr_full_c = 1'b0;
    tgt_full_c = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (hdr_chan_c == SELWIDTH'(i)) hdr_full_c = ch_full_c[i];
      if (target_q == SELWIDTH'(i))   tgt_full_c = ch_full_c[i];
    end
  end

  // Parser next-state and dispatch decisions
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    target_d   = target_q;
    dispatch_c = 1'b0;
    wr_en_c    = 1'b0;
    wr_sel_c   = target_q;
    drop_inc_c = 1'b0;
    case (state_q)
      S_HDR: begin
        if (head_valid_c) begin
          if (hdr_bad_c) begin
            dispatch_c = 1'b1;
            drop_inc_c = 1'b1;
            rem_d      = hdr_len_c;
            if (hdr_len_c != '0) state_d = S_DROP;
          end else if (!hdr_full_c) begin
            dispatch_c = 1'b1;
            wr_en_c    = 1'b1;
            wr_sel_c   = hdr_chan_c;
            target_d   = hdr_chan_c;
            rem_d      = hdr_len_c;
            if (hdr_len_c != '0) state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (head_valid_c && !tgt_full_c) begin
          dispatch_c = 1'b1;
          wr_en_c    = 1'b1;
          rem_d      = rem_q - RWIDTH'(1);
          if (rem_q == RWIDTH'(1)) state_d = S_HDR;
        end
      end
      S_DROP: begin
        if (head_valid_c) begin
          dispatch_c = 1'b1;
          rem_d      = rem_q - RWIDTH'(1);
          if (rem_q == RWIDTH'(1)) state_d = S_HDR;
        end
      end
      default: state_d = S_HDR;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q      <= S_HDR;
      rem_q        <= '0;
      target_q     <= '0;
      busy_q       <= 1'b0;
      drop_count_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      target_q <= target_d;
      busy_q   <= (state_d != S_HDR);
      // Clear wins over a coincident drop
      if (drop_clr)                                     drop_count_q <= 16'd0;
      else if (drop_inc_c && drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
    end
  end

  assign busy       = busy_q;
  assign drop_count = drop_count_q;

  // Per-channel FWFT FIFO with a registered head word
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [AWIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [LWIDTH-1:0] level_q, level_d;
    logic [DWIDTH-1:0] head_q;
    logic              empty_q;
    logic              push_c, pop_c;

    assign ch_full_c[g] = (level_q == LWIDTH'(DEPTH));
    assign push_c       = wr_en_c && (wr_sel_c == SELWIDTH'(g)) && !ch_full_c[g];
    assign pop_c        = ch_rden[g] && !empty_q;
    assign level_d      = level_q + LWIDTH'(push_c) - LWIDTH'(pop_c);

    always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
        empty_q  <= 1'b1;
      end else begin
        level_q <= level_d;
        empty_q <= (level_d == '0);
        if (push_c) wr_ptr_q <= wr_ptr_q + AWIDTH'(1);
        if (pop_c)  rd_ptr_q <= rd_ptr_q + AWIDTH'(1);
      end
    end

    // Head follows the next stored word, or the incoming word when nothing else is queued
    always_ff @(posedge CLK) begin
      if (push_c) mem_q[wr_ptr_q] <= skid0_q;
      if (pop_c && level_q > LWIDTH'(1))
        head_q <= mem_q[rd_ptr_q + AWIDTH'(1)];
      else if (push_c && (level_q == '0 || (level_q == LWIDTH'(1) && pop_c)))
        head_q <= skid0_q;
    end

    assign ch_rdempty[g]                 = empty_q;
    assign ch_rddata[g*DWIDTH +: DWIDTH] = head_q;
  end

endmodule
